// File: rtl/tof_cal_multi.sv
// Multi-hit TDC time-of-flight calculator.
// Each frame latches one start hit and then accepts up to MAX_HITS stop hits.
// Every hit goes through the same decode pipeline:
//   - an edge-detect stage,
//   - clog2(TAPS) halving priority stages,
//   - one arithmetic stage.
// Stop results are range-checked and queued in an output FIFO.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   tri_en               frame trigger; aborts a frame in progress
//   frame_end            closes the ARMED window early
//   hit_valid/hit_start  hit strobe; start (1) or stop (0)
//   therm_in/coarse_in   delay-line thermometer and coarse count for the hit
//   range                max legal TOF, captured at tri_en
//   tof_data/tof_idx     FIFO head (all-ones data = out of range)
//   tof_valid/tof_ready  FIFO handshake
//   hit_cnt              valid stop results in the current frame
//   busy                 FSM not IDLE
//   frame_done           one-cycle pulse at end of DRAIN
//   ovf                  sticky FIFO-full drop flag, cleared by tri_en
//
// state      | meaning
// IDLE       | no frame; waits for tri_en
// WAIT_START | frame open, waiting for the start hit
// ARMED      | start taken, accepting stop hits
// DRAIN      | no new hits; waiting for the pipeline to empty
module tof_cal_multi #(
  parameter int TAPS      = 16,
  parameter int CW        = 10,
  parameter int TW        = 15,
  parameter int MAX_HITS  = 3,
  parameter int OUT_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tri_en,
  input  logic            frame_end,
  input  logic            hit_valid,
  input  logic            hit_start,
  input  logic [TAPS-1:0] therm_in,
  input  logic [CW-1:0]   coarse_in,
  input  logic [TW-1:0]   range,
  output logic [TW-1:0]   tof_data,
  output logic [2:0]      tof_idx,
  output logic            tof_valid,
  input  logic            tof_ready,
  output logic [2:0]      hit_cnt,
  output logic            busy,
  output logic            frame_done,
  output logic            ovf
);
  localparam int LG = $clog2(TAPS);
  localparam int FW = LG + 1;
  localparam int AW = $clog2(OUT_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_START, ARMED, DRAIN} state_t;

  typedef struct packed {
    logic            v;
    logic            st;
    logic [2:0]      idx;
    logic            msb;
    logic [CW-1:0]   cs;
    logic [TAPS-1:0] vec;
    logic [LG-1:0]   pos;
  } stage_t;

  state_t          state;
  logic [2:0]      stop_cnt;
  logic [TW-1:0]   range_q;
  stage_t          pipe [0:LG];
  logic [TAPS-1:0] edge_c;
  logic            take_start, take_stop, pipe_empty;

  // One priority step: keep the upper half if it holds any edge, else the lower.
  function automatic stage_t halve(stage_t s, int j);
    stage_t          r;
    int              h;
    logic [TAPS-1:0] mask, hi;
    h    = TAPS >> j;
    mask = {TAPS{1'b1}} >> (TAPS - h);
    hi   = (s.vec >> h) & mask;
    r    = s;
    if (|hi) begin
      r.vec = hi;
      r.pos = s.pos | LG'(1 << (LG - j));
    end else begin
      r.vec = s.vec & mask;
    end
    return r;
  endfunction

  always_comb begin
    edge_c = '0;
    for (int i = 0; i < TAPS-1; i++) edge_c[i] = therm_in[i] ^ therm_in[i+1];
    edge_c[TAPS-1] = therm_in[TAPS-1] ^ ~therm_in[0];
  end

  // tri_en always wins over a hit in the same cycle.
  assign take_start = hit_valid &  hit_start & (state == WAIT_START) & ~tri_en;
  assign take_stop  = hit_valid & ~hit_start & (state == ARMED)      & ~tri_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j <= LG; j++) pipe[j] <= '0;
    end else if (tri_en) begin
      for (int j = 0; j <= LG; j++) pipe[j] <= '0;
    end else begin
      pipe[0].v   <= take_start | take_stop;
      pipe[0].st  <= hit_start;
      pipe[0].idx <= stop_cnt;
      pipe[0].msb <= therm_in[TAPS-1];
      pipe[0].cs  <= coarse_in;
      pipe[0].vec <= edge_c;
      pipe[0].pos <= '0;
      for (int j = 1; j <= LG; j++) pipe[j] <= halve(pipe[j-1], j);
    end
  end

  // Arithmetic stage against the latched start.
  logic [FW-1:0]      fine_c, fst_q;
  logic [CW-1:0]      cst_q, dcs;
  logic [TW:0]        tof_c;
  logic               bad_c;
  logic               a_v, a_bad;
  logic [TW-1:0]      a_tof;
  logic [2:0]         a_idx;

  always_comb begin
    fine_c = {pipe[LG].msb, pipe[LG].pos};
    dcs    = pipe[LG].cs - cst_q;
    // Unsigned TW+1 bit wrap arithmetic gives the two's-complement signed result.
    tof_c  = ((TW+1)'(dcs) << FW) + (TW+1)'(fine_c) - (TW+1)'(fst_q);
    bad_c  = tof_c[TW] | (tof_c[TW-1:0] > range_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_v   <= 1'b0;
      a_bad <= 1'b0;
      a_tof <= '0;
      a_idx <= '0;
      cst_q <= '0;
      fst_q <= '0;
    end else if (tri_en) begin
      a_v <= 1'b0;
    end else begin
      a_v   <= pipe[LG].v & ~pipe[LG].st;
      a_bad <= bad_c;
      a_tof <= bad_c ? {TW{1'b1}} : tof_c[TW-1:0];
      a_idx <= pipe[LG].idx;
      if (pipe[LG].v && pipe[LG].st) begin
        cst_q <= pipe[LG].cs;
        fst_q <= fine_c;
      end
    end
  end

  always_comb begin
    pipe_empty = ~a_v;
    for (int j = 0; j <= LG; j++) pipe_empty = pipe_empty & ~pipe[j].v;
  end

  // Output FIFO. The head reads straight from storage; last_q holds the last
  // popped entry so the outputs stay put while the FIFO is empty.
  logic [TW+2:0] mem [0:OUT_DEPTH-1];
  logic [TW+2:0] last_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, push, drop, flush;

  assign full  = (count == (AW+1)'(OUT_DEPTH));
  assign pop   = tof_valid & tof_ready;
  assign push  = a_v & (~full | pop);
  assign drop  = a_v & full & ~pop;
  assign flush = tri_en & (state != IDLE);

  assign tof_valid = (count != '0);
  assign tof_data  = tof_valid ? mem[rd_ptr][TW-1:0]  : last_q[TW-1:0];
  assign tof_idx   = tof_valid ? mem[rd_ptr][TW+2:TW] : last_q[TW+2:TW];
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= {a_idx, a_tof};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      stop_cnt   <= '0;
      hit_cnt    <= '0;
      ovf        <= 1'b0;
      frame_done <= 1'b0;
      range_q    <= '0;
    end else begin
      frame_done <= 1'b0;
      if (tri_en) begin
        state    <= WAIT_START;
        stop_cnt <= '0;
        hit_cnt  <= '0;
        ovf      <= 1'b0;
        range_q  <= range;
      end else begin
        if (drop) ovf <= 1'b1;
        hit_cnt <= hit_cnt + 3'(take_stop) - 3'(a_v & (a_bad | drop));
        case (state)
          WAIT_START: if (take_start) state <= ARMED;
          ARMED: begin
            if (take_stop) stop_cnt <= stop_cnt + 1'b1;
            if (frame_end || (take_stop && stop_cnt == 3'(MAX_HITS-1))) state <= DRAIN;
          end
          DRAIN: begin
            if (pipe_empty) begin
              frame_done <= 1'b1;
              state      <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
